// File: rtl/turf_bus_responder.sv
// turf_bus_responder: TURF-side responder for the 8-bit multiplexed TURFIO<->TURF
// register bus. Decodes the address cycle, assembles 4-byte writes into a 32-bit
// write strobe, and serves reads byte-serially after RD_LATENCY pin cycles.
// Optional macro TURF_RESP_ABORT_CNT_EN adds abort_cnt_o, a saturating count of
// aborted writes.
module turf_bus_responder #(
    parameter int RD_LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        nCSTURF,
    input  logic        TURF_WnR,
    inout  wire  [7:0]  TURF_DIO,
    output logic [5:0]  addr_o,
    output logic [1:0]  bank_o,
    output logic        wr_o,
    output logic [31:0] dat_o,
    output logic        rd_o,
    input  logic [31:0] dat_i,
`ifdef TURF_RESP_ABORT_CNT_EN
    output logic [7:0]  abort_cnt_o,
`endif
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_BYTE,
        S_WR_COMMIT,
        S_RD_WAIT,
        S_RD_BYTE
    } state_t;

    // RD_WAIT count at which the read request fires (cycle A+RD_LATENCY-1)
    localparam logic [3:0] RD_LAST = 4'(RD_LATENCY - 3);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ncs_q, wnr_q;
    logic [7:0]  dio_q;
    logic        armed_q, armed_d;
    logic [7:0]  ab_q, ab_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsh_q, rsh_d;
    logic [7:0]  dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        start, rd_fire, wr_abort;

    assign start    = (state_q == S_IDLE) && armed_q && !ncs_q;
    assign rd_fire  = (state_q == S_RD_WAIT) && (cnt_q == RD_LAST);
    assign wr_abort = (state_q == S_WR_BYTE) && ncs_q;

    assign TURF_DIO = oe_q ? dout_q : 8'bz;
    assign {bank_o, addr_o} = ab_q;
    assign dat_o = dat_q;

    // Pin input registers; idle bus reads as chip select deasserted
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ncs_q <= 1'b1;
            wnr_q <= 1'b0;
            dio_q <= '0;
        end else begin
            ncs_q <= nCSTURF;
            wnr_q <= TURF_WnR;
            dio_q <= TURF_DIO;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = wnr_q ? S_WR_BYTE : S_RD_WAIT;
            end
            S_WR_BYTE: begin
                if (wr_abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd3) begin
                    state_d = S_WR_COMMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_COMMIT: state_d = S_IDLE;
            S_RD_WAIT: begin
                if (rd_fire) begin
                    state_d = S_RD_BYTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_BYTE: begin
                if (cnt_q == 4'd3) state_d = S_IDLE;
                else               cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        wr_o    = (state_q == S_WR_COMMIT);
        rd_o    = rd_fire;
        busy_o  = (state_q != S_IDLE);
        armed_d = ncs_q ? 1'b1 : (start ? 1'b0 : armed_q);
        ab_d    = start ? dio_q : ab_q;
        dat_d   = dat_q;
        rsh_d   = rsh_q;
        dout_d  = dout_q;
        oe_d    = 1'b0;
        if ((state_q == S_WR_BYTE) && !ncs_q) dat_d = {dio_q, dat_q[31:8]};
        // Byte 0 is loaded straight into the pin register; the shift register
        // then presents the following byte one cycle ahead of the pin.
        if (rd_fire) begin
            rsh_d  = dat_i;
            dout_d = dat_i[7:0];
            oe_d   = 1'b1;
        end else if ((state_q == S_RD_BYTE) && (cnt_q != 4'd3)) begin
            rsh_d  = {8'h00, rsh_q[31:8]};
            dout_d = rsh_q[15:8];
            oe_d   = 1'b1;
        end
    end

    // Datapath and IOB output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed_q <= 1'b0;
            ab_q    <= '0;
            dat_q   <= '0;
            rsh_q   <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
        end else begin
            armed_q <= armed_d;
            ab_q    <= ab_d;
            dat_q   <= dat_d;
            rsh_q   <= rsh_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
        end
    end

`ifdef TURF_RESP_ABORT_CNT_EN
    logic [7:0] abort_q, abort_d;

    // Saturating aborted-write counter
    always_comb begin
        abort_d = abort_q;
        if (wr_abort && (abort_q != 8'hFF)) abort_d = abort_q + 8'd1;
    end

    // Abort counter register, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) abort_q <= '0;
        else          abort_q <= abort_d;
    end

    assign abort_cnt_o = abort_q;
`endif

endmodule
